imem_arbiter: RTL



---
 rtl/imem_arbiter_pkg.sv | 11 +
 rtl/imem_arbiter_if.sv | 42 ++++
 rtl/imem_arbiter_sat_counter.sv | 17 +
 rtl/imem_arbiter.sv | 84 ++++++++
 4 files changed

// File: rtl/imem_arbiter_pkg.sv
// Shared constants for the instruction-memory arbiter: owner encoding of the
// in-flight read and the instruction-memory address width.
package imem_arbiter_pkg;
  localparam int IMEM_AW = 8;

  typedef logic [1:0] owner_t;

  localparam owner_t OWN_NONE = 2'd0;
  localparam owner_t OWN_F    = 2'd1;
  localparam owner_t OWN_D    = 2'd2;
endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, data-side and memory buses around the imem arbiter.
// The slave modport is the arbiter; master is the CPU/memory environment.
interface imem_arbiter_if
  import imem_arbiter_pkg::*;
#(
  parameter int AW = IMEM_AW
);
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_kill;
  logic          f_gnt;
  logic          f_stall;
  logic          f_rvalid;
  logic [31:0]   f_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [3:0]    d_wstrb;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;

  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  f_req, f_addr, f_kill, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
    output f_gnt, f_stall, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, f_kill, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
    input  f_gnt, f_stall, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX.
module imem_arbiter_sat_counter #(
  parameter int           W   = 4,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != MAX) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the single-port instruction memory between fetch and the data side,
// and steers the one-cycle-latency read data back to the owner of the read.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int AW       = IMEM_AW,
  parameter int MAX_WAIT = 4,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_arbiter_if.slave bus,
  output logic [CW-1:0] stall_cnt
);
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic       last_d;
  logic       kill_pend;
  owner_t     owner;
  logic       f_gnt;
  logic       d_gnt;
  logic       f_stall;

  // Fetch wins by default; an aged data request overrides it, and a data grant
  // is never followed by another while fetch is asking.
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n) begin
      if (bus.d_req && wait_cnt == WAIT_MAX) d_gnt = 1'b1;
      else if (bus.f_req && last_d)          f_gnt = 1'b1;
      else if (bus.f_req)                    f_gnt = 1'b1;
      else if (bus.d_req)                    d_gnt = 1'b1;
    end
  end

  assign f_stall       = bus.f_req && !f_gnt;
  assign bus.f_gnt     = f_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.f_stall   = f_stall;

  assign bus.mem_en    = f_gnt || d_gnt;
  assign bus.mem_addr  = d_gnt ? bus.d_addr : bus.f_addr;
  assign bus.mem_wdata = bus.d_wdata;
  assign bus.mem_we    = (d_gnt && bus.d_we) ? bus.d_wstrb : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= OWN_NONE;
      last_d    <= 1'b0;
      kill_pend <= 1'b0;
    end else begin
      if (f_gnt)                   owner <= OWN_F;
      else if (d_gnt && !bus.d_we) owner <= OWN_D;
      else                         owner <= OWN_NONE;
      if (d_gnt)      last_d <= 1'b1;
      else if (f_gnt) last_d <= 1'b0;
      // A fetch granted in a flush cycle belongs to the squashed path.
      kill_pend <= bus.f_kill && f_gnt;
    end
  end

  assign bus.f_rvalid = (owner == OWN_F) && !kill_pend && !bus.f_kill;
  assign bus.d_rvalid = (owner == OWN_D);
  assign bus.f_rdata  = bus.mem_rdata;
  assign bus.d_rdata  = bus.mem_rdata;

  imem_arbiter_sat_counter #(.W(4), .MAX(WAIT_MAX)) u_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (d_gnt || !bus.d_req),
    .inc   (bus.d_req && !d_gnt),
    .cnt   (wait_cnt)
  );

  imem_arbiter_sat_counter #(.W(CW)) u_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (f_stall),
    .cnt   (stall_cnt)
  );
endmodule
